// File: rtl/conv2d_mvau_stream.sv
// conv2d_mvau_stream: folded PE x SIMD matrix-vector unit for Conv2D layers.
// Weights are streamed into PE banks, then each im2col vector is multiplied
// against the resident matrix, producing MH outputs, PE lanes per beat.
// Optional feature macro: CONV2D_SAT_EN (saturating output narrowing);
// without it the output keeps the low DATA_WIDTH bits of the result.
module conv2d_mvau_stream #(
  parameter int PE           = 16,
  parameter int SIMD         = 8,
  parameter int MW           = 64,
  parameter int MH           = 64,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 24,
  parameter int SHIFT        = 0
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic [DATA_WIDTH*SIMD-1:0]   in0_V_TDATA,
  input  logic                         in0_V_TVALID,
  output logic                         in0_V_TREADY,
  input  logic [WEIGHT_WIDTH*SIMD-1:0] weights_V_TDATA,
  input  logic                         weights_V_TVALID,
  output logic                         weights_V_TREADY,
  output logic [DATA_WIDTH*PE-1:0]     out_V_TDATA,
  output logic                         out_V_TVALID,
  input  logic                         out_V_TREADY,
  input  logic                         wt_reload,
  output logic                         wt_loaded
);

  localparam int SF    = MW / SIMD;
  localparam int NF    = MH / PE;
  localparam int DEPTH = NF * SF;
  localparam int SFW   = (SF > 1) ? $clog2(SF) : 1;
  localparam int NFW   = (NF > 1) ? $clog2(NF) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PEW   = (PE > 1) ? $clog2(PE) : 1;
  localparam int PW    = DATA_WIDTH + WEIGHT_WIDTH;

  localparam logic [SFW-1:0] SF_LAST   = SFW'(SF - 1);
  localparam logic [NFW-1:0] NF_LAST   = NFW'(NF - 1);
  localparam logic [AW-1:0]  ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [PEW-1:0] PE_LAST   = PEW'(PE - 1);

`ifdef CONV2D_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

  // Reduce a shifted accumulator to one output lane.
  function automatic logic [DATA_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
`ifdef CONV2D_SAT_EN
    if (v > SAT_MAX) begin
      r = SAT_MAX[DATA_WIDTH-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      r = v[DATA_WIDTH-1:0];
    end
`else
    r = v[DATA_WIDTH-1:0];
`endif
    return r;
  endfunction

  typedef enum logic [0:0] {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

  state_t state_q, state_d;

  logic [PEW-1:0]                 ld_pe_q;
  logic [AW-1:0]                  addr_q;
  logic [SFW-1:0]                 sf_q;
  logic [NFW-1:0]                 nf_q;
  logic signed [ACC_WIDTH-1:0]    acc_q [PE];
  logic [SIMD*DATA_WIDTH-1:0]     inbuf_q [SF];
  logic [SIMD*WEIGHT_WIDTH-1:0]   wmem_q [PE][DEPTH];
  logic [PE*DATA_WIDTH-1:0]       out_data_q, out_data_d;
  logic                           out_valid_q;
  logic                           wt_loaded_q;
  logic                           reload_pend_q;

  logic                           out_free_s;
  logic                           room_s;
  logic                           take_reload_s;
  logic                           step_s;
  logic                           w_hs_s;
  logic                           load_done_s;
  logic                           fold_end_s;
  logic [SIMD*DATA_WIDTH-1:0]     x_vec_s;
  logic [SIMD*WEIGHT_WIDTH-1:0]   w_row_s [PE];
  logic signed [ACC_WIDTH-1:0]    dot_s [PE];
  logic signed [ACC_WIDTH-1:0]    sum_s [PE];
  logic signed [DATA_WIDTH-1:0]   xs_s;
  logic signed [WEIGHT_WIDTH-1:0] ws_s;
  logic signed [PW-1:0]           prod_s;

  // The output register can take a new result when empty or being drained.
  assign out_free_s    = !out_valid_q || out_V_TREADY;
  // Only the last fold step writes the output register, so only it can stall.
  assign room_s        = (sf_q != SF_LAST) || out_free_s;
  // A pending reload waits for a vector boundary so no partial vector is lost.
  assign take_reload_s = (state_q == S_RUN) && reload_pend_q && (nf_q == '0) &&
                         (sf_q == '0) && out_free_s;
  assign step_s        = (state_q == S_RUN) && !take_reload_s && room_s &&
                         ((nf_q != '0) || in0_V_TVALID);
  assign w_hs_s        = (state_q == S_LOAD) && weights_V_TVALID;
  assign load_done_s   = w_hs_s && (ld_pe_q == PE_LAST) && (addr_q == ADDR_LAST);
  assign fold_end_s    = step_s && (sf_q == SF_LAST);

  // First fold takes the live stream; later folds replay the buffered vector.
  assign x_vec_s = (nf_q == '0) ? in0_V_TDATA : inbuf_q[sf_q];

  assign in0_V_TREADY     = (state_q == S_RUN) && !take_reload_s && (nf_q == '0) && room_s;
  assign weights_V_TREADY = (state_q == S_LOAD);
  assign out_V_TDATA      = out_data_q;
  assign out_V_TVALID     = out_valid_q;
  assign wt_loaded        = wt_loaded_q;

  // Per-lane dot product of the current SIMD slice, plus running fold sum.
  always_comb begin
    xs_s       = '0;
    ws_s       = '0;
    prod_s     = '0;
    out_data_d = '0;
    for (int p = 0; p < PE; p++) begin
      w_row_s[p] = wmem_q[p][addr_q];
      dot_s[p]   = '0;
      for (int i = 0; i < SIMD; i++) begin
        xs_s     = x_vec_s[i*DATA_WIDTH +: DATA_WIDTH];
        ws_s     = w_row_s[p][i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        prod_s   = PW'(xs_s) * PW'(ws_s);
        dot_s[p] = dot_s[p] + ACC_WIDTH'(prod_s);
      end
      if (sf_q == '0) begin
        sum_s[p] = dot_s[p];
      end else begin
        sum_s[p] = acc_q[p] + dot_s[p];
      end
      out_data_d[p*DATA_WIDTH +: DATA_WIDTH] = narrow(sum_s[p] >>> SHIFT);
    end
  end

  // Next-state logic: load until the matrix is complete, run until a reload.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: begin
        if (load_done_s) begin
          state_d = S_RUN;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        if (take_reload_s) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, accumulators, output register and reload bookkeeping.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ld_pe_q       <= '0;
      addr_q        <= '0;
      sf_q          <= '0;
      nf_q          <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      wt_loaded_q   <= 1'b0;
      reload_pend_q <= 1'b0;
      for (int p = 0; p < PE; p++) begin
        acc_q[p] <= '0;
      end
    end else begin
      if ((state_q == S_LOAD) || take_reload_s) begin
        reload_pend_q <= 1'b0;
      end else if (wt_reload) begin
        reload_pend_q <= 1'b1;
      end

      if (take_reload_s) begin
        wt_loaded_q <= 1'b0;
      end else if (load_done_s) begin
        wt_loaded_q <= 1'b1;
      end

      if (w_hs_s) begin
        if (ld_pe_q == PE_LAST) begin
          ld_pe_q <= '0;
          addr_q  <= (addr_q == ADDR_LAST) ? '0 : addr_q + AW'(1'b1);
        end else begin
          ld_pe_q <= ld_pe_q + PEW'(1'b1);
        end
      end else if (step_s) begin
        addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + AW'(1'b1);
        for (int p = 0; p < PE; p++) begin
          acc_q[p] <= sum_s[p];
        end
        if (sf_q == SF_LAST) begin
          sf_q <= '0;
          nf_q <= (nf_q == NF_LAST) ? '0 : nf_q + NFW'(1'b1);
        end else begin
          sf_q <= sf_q + SFW'(1'b1);
        end
      end

      if (fold_end_s) begin
        out_data_q  <= out_data_d;
        out_valid_q <= 1'b1;
      end else if (out_V_TREADY) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Weight banks and input replay buffer hold data only, never reset.
  always_ff @(posedge ap_clk) begin
    if (w_hs_s) begin
      wmem_q[ld_pe_q][addr_q] <= weights_V_TDATA;
    end
    if (step_s && (nf_q == '0)) begin
      inbuf_q[sf_q] <= in0_V_TDATA;
    end
  end

endmodule
